// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation engine.
package rsa_pkg;

  // Engine controller states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SQR  = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4
  } rsa_state_e;

  // Modular-multiply latency: one cycle per operand bit plus one result cycle
  function automatic int mul_cyc(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/rsa_mod_mul.sv
// Bit-serial interleaved modular multiplier: result = a*b mod n.
// Operands are consumed MSB first (r = 2r + a_i*b, reduced by up to two
// subtractions of n). The first step runs in the start cycle straight from
// the input ports, the remaining WIDTH-1 steps follow, and done is high for
// one cycle with result valid, MUL_CYC cycles after start inclusive.
// Requires a < n, b < n so every partial result stays below 3n.
module rsa_mod_mul
  import rsa_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int MUL_CYC = mul_cyc(WIDTH);
  localparam int CW      = $clog2(MUL_CYC);

  logic             active_q, active_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;

  // One interleaved step: 2r + bit*b, then bring back below n
  function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] r,
                                                input logic             bit_i,
                                                input logic [WIDTH-1:0] bv,
                                                input logic [WIDTH-1:0] nv);
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] nn;
    nn = {2'b00, nv};
    t  = {1'b0, r, 1'b0} + (bit_i ? {2'b00, bv} : {(WIDTH+2){1'b0}});
    if (t >= nn) t = t - nn;
    if (t >= nn) t = t - nn;
    return t[WIDTH-1:0];
  endfunction

  // Next-state: first step on start, then count down the remaining steps
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    if (!active_q) begin
      if (start) begin
        r_d      = mod_step({WIDTH{1'b0}}, a[WIDTH-1], b, n);
        a_d      = a << 1;
        b_d      = b;
        n_d      = n;
        cnt_d    = CW'(MUL_CYC - 2);
        active_d = 1'b1;
      end
    end else if (cnt_q != '0) begin
      r_d   = mod_step(r_q, a_q[WIDTH-1], b_q, n_q);
      a_d   = a_q << 1;
      cnt_d = cnt_q - CW'(1);
    end else begin
      active_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      r_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
    end
  end

  assign busy   = active_q;
  assign done   = active_q && (cnt_q == '0);
  assign result = r_q;

endmodule

// File: rtl/rsa_engine.sv
// RSA engine: holds a key set and computes data^exp mod n by left-to-right
// square-and-multiply over all WIDTH exponent bits (constant op sequence per
// exponent popcount, no leading-zero skip).
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; payload is sampled on that cycle only, and valid must not depend on
// ready. in_ready is withheld while key_valid is high so a key load wins.
module rsa_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [WIDTH-1:0] key_n,
  input  logic [WIDTH-1:0] key_e,
  input  logic [WIDTH-1:0] key_d,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             keys_loaded,
  output logic             busy,
  output logic             key_err,
  output rsa_state_e       dbg_state
);

  localparam int IW = $clog2(WIDTH);

  rsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d, e_q, e_d, d_q, d_d;
  logic             keys_loaded_q, keys_loaded_d;
  logic             key_err_q, key_err_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] msg_q, msg_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;

  logic             key_ok;
  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_b, mul_result;

  assign key_ok    = key_n[0] && (key_n >= WIDTH'(3));
  assign key_ready = (state_q == IDLE);
  assign in_ready  = (state_q == IDLE) && keys_loaded_q && !key_valid;
  assign mul_start = ((state_q == SQR) || (state_q == MUL)) && !mul_busy;
  assign mul_b     = (state_q == MUL) ? msg_q : acc_q;

  rsa_mod_mul #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (acc_q),
    .b      (mul_b),
    .n      (n_q),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_result)
  );

  // Controller next-state and datapath updates
  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    e_d           = e_q;
    d_d           = d_q;
    keys_loaded_d = keys_loaded_q;
    key_err_d     = 1'b0;
    mode_d        = mode_q;
    msg_d         = msg_q;
    exp_d         = exp_q;
    acc_d         = acc_q;
    bit_idx_d     = bit_idx_q;
    out_data_d    = out_data_q;
    out_err_d     = out_err_q;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          if (key_ok) begin
            n_d           = key_n;
            e_d           = key_e;
            d_d           = key_d;
            keys_loaded_d = 1'b1;
          end else begin
            key_err_d = 1'b1;
          end
        end else if (in_valid && in_ready) begin
          mode_d  = in_mode;
          msg_d   = in_data;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (msg_q >= n_q) begin
          out_data_d = '0;
          out_err_d  = 1'b1;
          state_d    = DONE;
        end else begin
          exp_d     = mode_q ? e_q : d_q;
          acc_d     = WIDTH'(1);
          bit_idx_d = IW'(WIDTH - 1);
          state_d   = SQR;
        end
      end
      SQR: begin
        if (mul_done) begin
          acc_d = mul_result;
          if (exp_q[bit_idx_q]) begin
            state_d = MUL;
          end else if (bit_idx_q == '0) begin
            out_data_d = mul_result;
            out_err_d  = 1'b0;
            state_d    = DONE;
          end else begin
            bit_idx_d = bit_idx_q - IW'(1);
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          acc_d = mul_result;
          if (bit_idx_q == '0) begin
            out_data_d = mul_result;
            out_err_d  = 1'b0;
            state_d    = DONE;
          end else begin
            bit_idx_d = bit_idx_q - IW'(1);
            state_d   = SQR;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over every handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      n_q           <= '0;
      e_q           <= '0;
      d_q           <= '0;
      keys_loaded_q <= 1'b0;
      key_err_q     <= 1'b0;
      mode_q        <= 1'b0;
      msg_q         <= '0;
      exp_q         <= '0;
      acc_q         <= '0;
      bit_idx_q     <= '0;
      out_data_q    <= '0;
      out_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      e_q           <= e_d;
      d_q           <= d_d;
      keys_loaded_q <= keys_loaded_d;
      key_err_q     <= key_err_d;
      mode_q        <= mode_d;
      msg_q         <= msg_d;
      exp_q         <= exp_d;
      acc_q         <= acc_d;
      bit_idx_q     <= bit_idx_d;
      out_data_q    <= out_data_d;
      out_err_q     <= out_err_d;
    end
  end

  assign out_valid   = (state_q == DONE);
  assign out_data    = out_data_q;
  assign out_err     = out_err_q;
  assign keys_loaded = keys_loaded_q;
  assign busy        = (state_q != IDLE);
  assign key_err     = key_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rsa_engine.sv
// Directed bench for rsa_engine at WIDTH = 8 (multiply latency 9).
module tb_rsa_engine;
  import rsa_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         key_valid;
  logic         key_ready;
  logic [W-1:0] key_n, key_e, key_d;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_err;
  logic         keys_loaded;
  logic         busy;
  logic         key_err;
  rsa_state_e   dbg_state;

  int checks = 0;
  int passes = 0;

  rsa_engine #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_n       (key_n),
    .key_e       (key_e),
    .key_d       (key_d),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_err     (out_err),
    .keys_loaded (keys_loaded),
    .busy        (busy),
    .key_err     (key_err),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Key load from IDLE; checks error pulse and loaded flag
  task automatic load_key(input logic [W-1:0] n, input logic [W-1:0] e, input logic [W-1:0] d,
                          input logic exp_err, input logic exp_loaded);
    @(negedge clk);
    chk("key_ready_idle", key_ready, 1);
    key_valid = 1'b1;
    key_n = n;
    key_e = e;
    key_d = d;
    @(posedge clk);
    #1 key_valid = 1'b0;
    @(negedge clk);
    chk("key_err", key_err, exp_err);
    chk("keys_loaded", keys_loaded, exp_loaded);
    @(negedge clk);
    chk("key_err_one_cycle", key_err, 0);
  endtask

  // Wait for a result after the transfer edge, check it, optionally stall, then accept
  task automatic wait_result(input logic [W-1:0] exp_data, input logic exp_err,
                             input int exp_lat, input int hold);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (out_valid) seen = 1'b1;
    end
    chk("out_valid_seen", seen, 1);
    chk("latency", cyc, exp_lat);
    chk("out_data", out_data, exp_data);
    chk("out_err", out_err, exp_err);
    chk("busy_done", busy, 1);
    if (hold > 0) begin
      // try to sneak a key in while the result is pending
      key_valid = 1'b1;
      key_n = 8'd35;
      key_e = 8'd5;
      key_d = 8'd5;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, exp_data);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_key_ready", key_ready, 0);
    end
    key_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("after_accept_valid", out_valid, 0);
    chk("after_accept_busy", busy, 0);
  endtask

  task automatic do_job(input logic mode, input logic [W-1:0] data, input logic [W-1:0] exp_data,
                        input logic exp_err, input int exp_lat, input int hold);
    @(negedge clk);
    in_valid = 1'b1;
    in_mode = mode;
    in_data = data;
    #1 chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(exp_data, exp_err, exp_lat, hold);
  endtask

  initial begin
    bit seen_early;
    reset = 1'b1;
    key_valid = 1'b0;
    key_n = '0;
    key_e = '0;
    key_d = '0;
    in_valid = 1'b0;
    in_mode = 1'b0;
    in_data = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_keys_loaded", keys_loaded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_key_err", key_err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // No keys yet: a job must not be accepted
    in_valid = 1'b1;
    in_mode = 1'b1;
    in_data = 8'd4;
    repeat (3) begin
      @(negedge clk);
      chk("no_key_in_ready", in_ready, 0);
      chk("no_key_busy", busy, 0);
    end
    in_valid = 1'b0;

    // Rejected keys: even modulus, modulus below 3
    load_key(8'd34, 8'd3, 8'd7, 1'b1, 1'b0);
    load_key(8'd1, 8'd3, 8'd7, 1'b1, 1'b0);
    @(negedge clk);
    chk("bad_key_in_ready", in_ready, 0);

    // n=33, e=3, d=7
    load_key(8'd33, 8'd3, 8'd7, 1'b0, 1'b1);
    do_job(1'b1, 8'd4, 8'd31, 1'b0, 92, 0);    // 4^3 mod 33
    do_job(1'b0, 8'd31, 8'd4, 1'b0, 101, 0);   // 31^7 mod 33
    do_job(1'b1, 8'd40, 8'd0, 1'b1, 2, 0);     // above n
    do_job(1'b1, 8'd33, 8'd0, 1'b1, 2, 0);     // equal to n
    do_job(1'b1, 8'd5, 8'd26, 1'b0, 92, 20);   // 125 mod 33, stalled result
    do_job(1'b1, 8'd4, 8'd31, 1'b0, 92, 0);    // keys unchanged by the stall-time key

    // Key and job valid together: key wins, job follows
    @(negedge clk);
    key_valid = 1'b1;
    key_n = 8'd33;
    key_e = 8'd7;
    key_d = 8'd3;
    in_valid = 1'b1;
    in_mode = 1'b1;
    in_data = 8'd2;
    #1 chk("key_wins_in_ready", in_ready, 0);
    @(posedge clk);
    #1 key_valid = 1'b0;
    @(negedge clk);
    chk("key_wins_busy", busy, 0);
    chk("key_wins_loaded", keys_loaded, 1);
    chk("job_waits_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(8'd29, 1'b0, 101, 0);          // 2^7 mod 33
    do_job(1'b0, 8'd29, 8'd2, 1'b0, 92, 0);    // 29^3 mod 33

    // Reset 40 cycles into a job
    @(negedge clk);
    in_valid = 1'b1;
    in_mode = 1'b1;
    in_data = 8'd2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen_early = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen_early = 1'b1;
    end
    chk("midjob_no_valid", seen_early, 0);
    chk("midjob_busy", busy, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    seen_early = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen_early = 1'b1;
    end
    chk("post_rst_no_valid", seen_early, 0);
    chk("post_rst_keys_loaded", keys_loaded, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_in_ready", in_ready, 0);
    chk("post_rst_out_data", out_data, 0);

    // n=253 (top bit set), e=3, d=147
    load_key(8'd253, 8'd3, 8'd147, 1'b0, 1'b1);
    do_job(1'b1, 8'd200, 8'd140, 1'b0, 92, 0);
    do_job(1'b0, 8'd140, 8'd200, 1'b0, 110, 0);
    do_job(1'b1, 8'd252, 8'd252, 1'b0, 92, 0);  // (n-1)^3 = n-1
    do_job(1'b1, 8'd0, 8'd0, 1'b0, 92, 0);
    do_job(1'b1, 8'd253, 8'd0, 1'b1, 2, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rsa_engine.md
RSA_ENGINE -- requirements
Module: rsa_engine

Interface
REQ-001 Parameter WIDTH, default 256, is the modulus/message/exponent bit width; legal range 8..2048.
REQ-002 Parameter MUL_CYC, default WIDTH+1, is the fixed modular-multiply latency in cycles; it is derived, not overridable.
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 key_valid / key_ready  in / out  1 / 1  key-load handshake.
REQ-006 key_n, key_e, key_d  in  WIDTH each  modulus, public exponent, private exponent.
REQ-007 in_valid / in_ready  in / out  1 / 1  job handshake.
REQ-008 in_mode  in  1  1 = encrypt (use e), 0 = decrypt (use d).
REQ-009 in_data  in  WIDTH  message or ciphertext.
REQ-010 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-011 out_data  out  WIDTH  result; out_err  out  1  input rejected.
REQ-012 keys_loaded  out  1  a valid key set is held; busy  out  1  a job is in flight.
REQ-013 key_err  out  1  one-cycle pulse when a key load is rejected.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, SQR, MUL, DONE.
REQ-015 A transfer occurs on a cycle where valid and ready are both high; data is sampled on that cycle only.
REQ-016 key_ready SHALL be high only in IDLE; a key is accepted only if key_n is odd and key_n >= 3, otherwise the held keys are unchanged and key_err pulses the next cycle.
REQ-017 in_ready SHALL be high only in IDLE with keys_loaded = 1; key and job valid together in IDLE: key wins, job waits.
REQ-018 On job transfer: IDLE -> LOAD; LOAD latches exponent per in_mode, sets acc = 1, bit index = WIDTH-1.
REQ-019 If in_data >= n, LOAD SHALL go straight to DONE with out_data = 0, out_err = 1.
REQ-020 Per exponent bit, MSB first over all WIDTH bits: SQR computes acc = acc*acc mod n; if bit set, MUL computes acc = acc*msg mod n; then next bit.
REQ-021 Each SQR/MUL occupies exactly MUL_CYC cycles; no leading-zero skipping.
REQ-022 out_valid SHALL rise exactly 2 + MUL_CYC*(WIDTH + popcount(exp)) cycles after the job transfer cycle; error path: exactly 2 cycles.
REQ-023 out_data = in_data^exp mod n, always < n.
REQ-024 DONE holds out_valid, out_data, out_err stable until out_ready; then -> IDLE next cycle.
REQ-025 busy = 1 in LOAD, SQR, MUL, DONE.
REQ-026 key_valid during a job SHALL be ignored (key_ready = 0); held keys never change mid-job.

Reset
REQ-027 reset SHALL force IDLE and clear keys_loaded, busy, out_valid, out_err, key_err, out_data = 0, key_ready = 1, in_ready = 0 on the next edge.
REQ-028 reset mid-job SHALL abandon the job with no out_valid; reset has priority over every handshake in the same cycle.

Structure
REQ-029 Shared package rsa_pkg holds the FSM state enum and the MUL_CYC derivation function.
REQ-030 Sub-module rsa_mod_mul: bit-serial interleaved modular multiplier (r = 2r + a_i*b, up to two conditional subtractions of n per cycle, WIDTH+2-bit internal accumulator); start/done pulse interface; latency MUL_CYC.
REQ-031 No full WIDTH x WIDTH multiplier anywhere in the block.

Verification (WIDTH = 8, MUL_CYC = 9)
REQ-032 Load n=33, e=3, d=7; encrypt 4 -> out_data=31, out_err=0, out_valid exactly 92 cycles after transfer.
REQ-033 Decrypt 31 -> out_data=4, out_valid exactly 101 cycles after transfer.
REQ-034 Encrypt 40 (>= 33) -> out_data=0, out_err=1, out_valid after 2 cycles.
REQ-035 Load n=34 -> key_err pulse, keys_loaded unchanged; before any valid load in_ready stays 0.
REQ-036 Hold out_ready=0 for 20 cycles on a result -> out_data stable, in_ready=0, key_ready=0 throughout.
REQ-037 Assert reset 40 cycles into a job -> no out_valid, keys_loaded=0, next load and job complete correctly.
